// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg -- shared definitions for the sequential shift-add multiplier.
//   state_e    : FSM state encoding (IDLE=0, RUN=1, DONE=2), 2 bits
//   cnt_width  : iteration counter width, ceil(log2(WIDTH+1))
package seq_mult_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_mult_if.sv
// seq_mult_if -- request/response bundle for seq_mult.
//   master: drives start, clr, signed_mode, a, b; observes r, busy, done
//   slave : the multiplier side
interface seq_mult_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   clr;
    logic                   signed_mode;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [2*WIDTH-1:0]     r;
    logic                   busy;
    logic                   done;

    modport master (
        output start, clr, signed_mode, a, b,
        input  r, busy, done
    );

    modport slave (
        input  start, clr, signed_mode, a, b,
        output r, busy, done
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl -- FSM and iteration counter for seq_mult.
//   clk, rst_n : clock, async active-low reset
//   start, clr : request / synchronous abort (clr wins)
//   busy       : in RUN
//   done       : in DONE (one cycle)
//   load       : operands are accepted on this edge
//   step       : a shift-add step happens on this edge
//   last       : this step is the final one; the product is registered
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clr,
    output logic busy,
    output logic done,
    output logic load,
    output logic step,
    output logic last
);
    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (clr) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Back-to-back acceptance straight out of DONE
                state_d = load ? ST_RUN : ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
        load = start && !clr && (state_q == ST_IDLE || state_q == ST_DONE);
        step = (state_q == ST_RUN) && !clr;
        last = step && (cnt_q == LAST_CNT);
    end

endmodule

// File: rtl/seq_mult.sv
// seq_mult -- sequential shift-add multiplier, WIDTH steps per product.
//   clk, rst_n : clock, async active-low reset
//   bus        : seq_mult_if.slave (start/clr/signed_mode/a/b in,
//                r/busy/done out)
// Signed operands are reduced to unsigned magnitudes at capture and the
// product sign is restored on the completing edge, so the shift-add core
// is purely unsigned.
module seq_mult #(
    parameter int WIDTH          = 8,
    parameter int SIGNED_SUPPORT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_mult_if.slave     bus
);
    logic busy, done, load, step, last;

    seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bus.start),
        .clr   (bus.clr),
        .busy  (busy),
        .done  (done),
        .load  (load),
        .step  (step),
        .last  (last)
    );

    // acc holds {partial product high, remaining multiplier bits}; the
    // multiplier shifts out of the bottom as the product shifts in.
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q,   acc_d;
    logic                 neg_q,   neg_d;
    logic [2*WIDTH-1:0]   r_q,     r_d;

    logic                 sgn, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum, add_hi;
    logic [2*WIDTH-1:0]   acc_step, prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            r_q     <= '0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        sgn   = (SIGNED_SUPPORT != 0) && bus.signed_mode;
        a_neg = sgn && bus.a[WIDTH-1];
        b_neg = sgn && bus.b[WIDTH-1];
        // -(most negative) wraps to itself, which as unsigned is the exact
        // magnitude 2**(WIDTH-1).
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;

        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        add_hi   = acc_q[0] ? sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        acc_step = {add_hi, acc_q[WIDTH-1:1]};
        prod     = neg_q ? -acc_step : acc_step;

        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        r_d     = r_q;
        if (load) begin
            mcand_d = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            neg_d   = a_neg ^ b_neg;
        end else if (step) begin
            acc_d = acc_step;
        end
        if (last) r_d = prod;
    end

    assign bus.r    = r_q;
    assign bus.busy = busy;
    assign bus.done = done;

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (SHALL support 2..32).
REQ-002 Parameter SIGNED_SUPPORT, default 1; when 0, signed_mode SHALL be ignored and all operations SHALL be unsigned.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; operands are captured when accepted.
REQ-006 clr  input  1  synchronous abort.
REQ-007 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
REQ-008 a  input  WIDTH  multiplicand.
REQ-009 b  input  WIDTH  multiplier.
REQ-010 r  output  2*WIDTH  product; registered; held until the next completion.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  single-cycle completion pulse.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 and clr=0 at an edge SHALL capture a, b and signed_mode, clear the accumulator and iteration counter, and enter RUN.
REQ-015 RUN: each edge performs one shift-add step: if the multiplier LSB is 1, add the multiplicand magnitude to the upper accumulator half; then shift {carry, accumulator} right by 1 and increment the counter.
REQ-016 RUN: after exactly WIDTH steps the FSM SHALL enter DONE, loading r with the final product on the same edge.
REQ-017 Latency: done SHALL be high in the cycle beginning WIDTH edges after the accepting edge; busy SHALL be high for exactly those WIDTH cycles.
REQ-018 Zero operands SHALL NOT terminate early; latency is fixed.
REQ-019 Signed mode: operands SHALL be converted to WIDTH-bit unsigned magnitudes at capture; the product SHALL be negated at completion when exactly one operand was negative.
REQ-020 The most-negative operand (e.g. -128 at WIDTH=8) SHALL be handled exactly; the 2*WIDTH result never overflows.
REQ-021 DONE lasts one cycle; next state is IDLE, or RUN if start=1 and clr=0 (back-to-back acceptance, new operands captured).
REQ-022 start in RUN SHALL be ignored; operands and the current computation are unaffected.
REQ-023 clr=1 in any state SHALL force IDLE at the next edge, with busy=0 and no done pulse; r retains its last completed value; clr has priority over start.
REQ-024 r SHALL change only on the RUN->DONE edge or on reset.

Reset
REQ-025 rst_n=0 SHALL immediately, independent of clk, force state IDLE, r=0, busy=0, done=0, and clear the counter, accumulator and captured operands.
REQ-026 Reset asserted mid-RUN SHALL abandon the operation; no done pulse follows deassertion.
REQ-027 The first edge after rst_n deasserts SHALL be able to accept start.

Structure
REQ-028 The shared package seq_mult_pkg SHALL hold the state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and a counter-width function (ceil log2 of WIDTH+1).
REQ-029 One sub-module, seq_mult_ctrl (FSM + iteration counter, outputs busy/done/step/load), is natural; the datapath stays in seq_mult.

Verification (WIDTH=8, SIGNED_SUPPORT=1)
REQ-030 Unsigned 13*11, start for one cycle -> r=0x008F; busy high 8 cycles; done a single pulse exactly 8 edges after acceptance.
REQ-031 Corners: unsigned 255*255 -> 0xFE01; signed -3*5 -> 0xFFF1; signed -128*-128 -> 0x4000; unsigned 0*200 -> 0x0000 at the same 8-cycle latency.
REQ-032 Start 6*7, then start with a=9, b=9 on the 3rd RUN cycle -> r=0x002A; one done pulse only.
REQ-033 Complete 6*7 (r=0x002A); start 10*10; rst_n=0 on the 4th RUN cycle -> r=0, busy=0, done=0 immediately; no done after release.
REQ-034 Complete 6*7 (r=0x002A); start 10*10; clr on the 5th RUN cycle -> IDLE next edge, busy=0, no done, r stays 0x002A.
REQ-035 Hold start high with new operands 3*4 during DONE of 6*7 -> done for 0x002A, then RUN immediately; second done exactly 8 edges later with r=0x000C.
